// File: rtl/stopwatch_ctrl.sv
`default_nettype none
// ============================================================================
//  Module   : stopwatch_ctrl
//  Purpose  : Stopwatch control FSM with button conditioning and a 100 Hz
//             centisecond prescaler. Optional overflow stop via
//             STOPWATCH_OVF_STOP_EN (pause at 59:59.99 instead of wrapping).
//  Revision : 1.0  initial release
// ============================================================================

// Synchroniser, debounce and press strobe for one push-button.
module stopwatch_btn_cond #(
    parameter int DB_CYCLES = 500_000
) (
    input  logic clk,
    input  logic reset,
    input  logic btn,
    output logic press
);
    localparam int DB_W = (DB_CYCLES > 1) ? $clog2(DB_CYCLES) : 1;
    localparam logic [DB_W-1:0] DB_LAST = DB_W'(DB_CYCLES - 1);

    logic            sync1;
    logic            sync2;
    logic            level;
    logic [DB_W-1:0] db_cnt;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            sync1  <= 1'b0;
            sync2  <= 1'b0;
            level  <= 1'b0;
            db_cnt <= '0;
            press  <= 1'b0;
        end else begin
            sync1 <= btn;
            sync2 <= sync1;
            press <= 1'b0;
            if (sync2 == level) begin
                db_cnt <= '0;
            end else if (db_cnt == DB_LAST) begin
                // Level accepted; only the rising acceptance produces a strobe.
                db_cnt <= '0;
                level  <= sync2;
                press  <= sync2;
            end else begin
                db_cnt <= db_cnt + DB_W'(1);
            end
        end
    end
endmodule

module stopwatch_ctrl #(
    parameter int TICK_DIV  = 500_000,
    parameter int DB_CYCLES = 500_000
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       btn_start,
    input  logic       btn_lap,
    input  logic       max_reached,
    output logic       run,
    output logic       tick_cs,
    output logic       clear,
    output logic       lap_hold,
    output logic [1:0] state
);
    localparam logic [1:0] ST_IDLE  = 2'b00;
    localparam logic [1:0] ST_RUN   = 2'b01;
    localparam logic [1:0] ST_LAP   = 2'b10;
    localparam logic [1:0] ST_PAUSE = 2'b11;

    localparam int PS_W = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam logic [PS_W-1:0] PS_LAST = PS_W'(TICK_DIV - 1);

    logic            start_press;
    logic            lap_press;
    logic [PS_W-1:0] ps_cnt;
    logic            wrap;
    logic            ovf_stop;
    logic [1:0]      state_nx;
    logic            lap_hold_nx;
    logic            clear_nx;

    stopwatch_btn_cond #(.DB_CYCLES(DB_CYCLES)) u_start (
        .clk   (clk),
        .reset (reset),
        .btn   (btn_start),
        .press (start_press)
    );

    stopwatch_btn_cond #(.DB_CYCLES(DB_CYCLES)) u_lap (
        .clk   (clk),
        .reset (reset),
        .btn   (btn_lap),
        .press (lap_press)
    );

    assign wrap = run && (ps_cnt == PS_LAST);

`ifdef STOPWATCH_OVF_STOP_EN
    assign ovf_stop = wrap && max_reached;
`else
    logic unused_max_reached;
    assign unused_max_reached = max_reached;
    assign ovf_stop           = 1'b0;
`endif

    always_comb begin
        state_nx    = state;
        lap_hold_nx = lap_hold;
        clear_nx    = 1'b0;
        if (ovf_stop) begin
            state_nx    = ST_PAUSE;
            lap_hold_nx = 1'b0;
        end else begin
            // Start is tested first everywhere, so a simultaneous lap is dropped.
            case (state)
                ST_IDLE: begin
                    if (start_press) begin
                        state_nx = ST_RUN;
                    end
                end
                ST_RUN: begin
                    if (start_press) begin
                        state_nx = ST_PAUSE;
                    end else if (lap_press) begin
                        state_nx    = ST_LAP;
                        lap_hold_nx = 1'b1;
                    end
                end
                ST_LAP: begin
                    if (start_press) begin
                        state_nx    = ST_PAUSE;
                        lap_hold_nx = 1'b0;
                    end else if (lap_press) begin
                        state_nx    = ST_RUN;
                        lap_hold_nx = 1'b0;
                    end
                end
                ST_PAUSE: begin
                    if (start_press) begin
                        state_nx = ST_RUN;
                    end else if (lap_press) begin
                        state_nx = ST_IDLE;
                        clear_nx = 1'b1;
                    end
                end
                default: begin
                    state_nx    = ST_IDLE;
                    lap_hold_nx = 1'b0;
                end
            endcase
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state    <= ST_IDLE;
            run      <= 1'b0;
            tick_cs  <= 1'b0;
            clear    <= 1'b0;
            lap_hold <= 1'b0;
            ps_cnt   <= '0;
        end else begin
            state    <= state_nx;
            run      <= (state_nx == ST_RUN) || (state_nx == ST_LAP);
            clear    <= clear_nx;
            lap_hold <= lap_hold_nx;
            tick_cs  <= wrap && !ovf_stop;
            // PAUSE falls through to hold, keeping the partial centisecond.
            if (state == ST_IDLE) begin
                ps_cnt <= '0;
            end else if (wrap) begin
                ps_cnt <= '0;
            end else if (run) begin
                ps_cnt <= ps_cnt + PS_W'(1);
            end
        end
    end
endmodule
`default_nettype wire

// File: tb/tb_stopwatch_ctrl.sv
`default_nettype none
// ============================================================================
//  Module   : tb_stopwatch_ctrl
//  Purpose  : Scoreboard bench for stopwatch_ctrl (TICK_DIV=4, DB_CYCLES=3).
//  Revision : 1.0  initial release
// ============================================================================
module tb_stopwatch_ctrl;
    localparam int TICK_DIV  = 4;
    localparam int DB_CYCLES = 3;
    localparam int LAT       = DB_CYCLES + 3;

    localparam logic [1:0] S_IDLE  = 2'b00;
    localparam logic [1:0] S_RUN   = 2'b01;
    localparam logic [1:0] S_LAP   = 2'b10;
    localparam logic [1:0] S_PAUSE = 2'b11;

    logic       clk         = 1'b0;
    logic       reset       = 1'b1;
    logic       btn_start   = 1'b0;
    logic       btn_lap     = 1'b0;
    logic       max_reached = 1'b0;
    logic       run;
    logic       tick_cs;
    logic       clear;
    logic       lap_hold;
    logic [1:0] state;

    typedef struct {
        int         at;
        logic [1:0] st;
        logic       lh;
    } exp_t;

    exp_t       state_q[$];
    int         tick_q[$];
    int         clear_q[$];
    exp_t       e_pop;
    int         cyc        = 0;
    int         n_checks   = 0;
    int         n_fail     = 0;
    int         ticks_seen = 0;
    bit         mon_on     = 1'b0;
    logic [1:0] prev_state = 2'b00;

    stopwatch_ctrl #(
        .TICK_DIV  (TICK_DIV),
        .DB_CYCLES (DB_CYCLES)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .btn_start   (btn_start),
        .btn_lap     (btn_lap),
        .max_reached (max_reached),
        .run         (run),
        .tick_cs     (tick_cs),
        .clear       (clear),
        .lap_hold    (lap_hold),
        .state       (state)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string tag, input int got, input int exp);
        n_checks++;
        if (got != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    task automatic expect_state(input int at, input logic [1:0] st, input logic lh);
        exp_t x;
        x.at = at;
        x.st = st;
        x.lh = lh;
        state_q.push_back(x);
    endtask

    // Ticks for a run interval entered at edge s with prescaler p0, left at edge e.
    task automatic push_span(input int s, input int e, input int p0);
        for (int t = s + TICK_DIV - p0; t <= e; t += TICK_DIV) tick_q.push_back(t);
    endtask

    task automatic wait_until(input int c);
        while (cyc < c) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, "_state"}, int'(state), int'(S_IDLE));
        check({tag, "_run"}, int'(run), 0);
        check({tag, "_tick"}, int'(tick_cs), 0);
        check({tag, "_clear"}, int'(clear), 0);
        check({tag, "_lap_hold"}, int'(lap_hold), 0);
    endtask

    always @(negedge clk) begin
        if (mon_on && !reset) begin
            if (state != prev_state) begin
                check("state_pending", int'(state_q.size() > 0), 1);
                if (state_q.size() > 0) begin
                    e_pop = state_q.pop_front();
                    check("state_cyc", cyc, e_pop.at);
                    check("state_val", int'(state), int'(e_pop.st));
                    check("state_lap_hold", int'(lap_hold), int'(e_pop.lh));
                    check("state_run", int'(run), int'(e_pop.st == S_RUN || e_pop.st == S_LAP));
                end
            end
            if (tick_cs) begin
                ticks_seen++;
                check("tick_pending", int'(tick_q.size() > 0), 1);
                if (tick_q.size() > 0) check("tick_cyc", cyc, tick_q.pop_front());
            end
            if (clear) begin
                check("clear_pending", int'(clear_q.size() > 0), 1);
                if (clear_q.size() > 0) check("clear_cyc", cyc, clear_q.pop_front());
            end
        end
        prev_state <= state;
    end

    initial begin
        repeat (20000) @(posedge clk);
        $display("FAIL watchdog: bench did not complete by cycle %0d", cyc);
        $fatal(1, "watchdog expired");
    end

    initial begin
        int t0, s, e, m, g, h;

        // Reset, with a start pulse that must be lost.
        repeat (2) @(posedge clk);
        #1;
        btn_start = 1'b1;
        repeat (4) @(posedge clk);
        #1;
        check_all_zero("reset");
        btn_start = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        reset  = 1'b0;
        mon_on = 1'b1;
        wait_until(cyc + 20);
        check("idle_after_reset", int'(state), int'(S_IDLE));

        // Clean start, 100 ticks, then lap in and out, then pause at prescaler 2.
        t0 = cyc;
        s  = t0 + LAT;
        e  = s + 458;
        ticks_seen = 0;
        btn_start  = 1'b1;
        expect_state(s, S_RUN, 1'b0);
        push_span(s, e, 0);
        wait_until(t0 + 20);
        btn_start = 1'b0;
        wait_until(s + 401);
        check("ticks_100", ticks_seen, 100);
        btn_lap = 1'b1;
        expect_state(s + 407, S_LAP, 1'b1);
        wait_until(s + 420);
        check("lap_hold_in_lap", int'(lap_hold), 1);
        btn_lap = 1'b0;
        wait_until(s + 430);
        btn_lap = 1'b1;
        expect_state(s + 436, S_RUN, 1'b0);
        wait_until(s + 445);
        btn_lap = 1'b0;
        wait_until(s + 452);
        btn_start = 1'b1;
        expect_state(e, S_PAUSE, 1'b0);
        wait_until(s + 465);
        btn_start = 1'b0;

        // Resume keeps the partial centisecond; pause again; lap clears to IDLE.
        wait_until(e + 20);
        m = e + 20 + LAT;
        btn_start = 1'b1;
        expect_state(m, S_RUN, 1'b0);
        push_span(m, m + 22, 2);
        wait_until(e + 30);
        btn_start = 1'b0;
        wait_until(e + 42);
        btn_start = 1'b1;
        expect_state(m + 22, S_PAUSE, 1'b0);
        wait_until(e + 55);
        btn_start = 1'b0;
        wait_until(e + 70);
        check("ticks_drained", tick_q.size(), 0);
        btn_lap = 1'b1;
        expect_state(e + 76, S_IDLE, 1'b0);
        clear_q.push_back(e + 76);
        wait_until(e + 85);
        btn_lap = 1'b0;

        // Bouncing start gives a single strobe.
        g = e + 100;
        wait_until(g);
        btn_start = 1'b1;
        wait_until(g + 1);
        btn_start = 1'b0;
        wait_until(g + 2);
        btn_start = 1'b1;
        expect_state(g + 8, S_RUN, 1'b0);
        push_span(g + 8, g + 26, 0);
        wait_until(g + 12);
        btn_start = 1'b0;
        wait_until(g + 20);
        btn_start = 1'b1;
        expect_state(g + 26, S_PAUSE, 1'b0);
        wait_until(g + 30);
        btn_start = 1'b0;
        wait_until(g + 40);
        btn_lap = 1'b1;
        expect_state(g + 46, S_IDLE, 1'b0);
        clear_q.push_back(g + 46);
        wait_until(g + 55);
        btn_lap = 1'b0;
        check("clear_drained", clear_q.size(), 0);

        // Simultaneous start and lap from IDLE, with max_reached high.
        h = g + 70;
        wait_until(h);
        btn_start   = 1'b1;
        btn_lap     = 1'b1;
        max_reached = 1'b1;
        expect_state(h + LAT, S_RUN, 1'b0);
`ifdef STOPWATCH_OVF_STOP_EN
        expect_state(h + LAT + 4, S_PAUSE, 1'b0);
`else
        push_span(h + LAT, h + 20, 0);
`endif
        wait_until(h + LAT + 1);
        check("both_state", int'(state), int'(S_RUN));
        check("both_lap_hold", int'(lap_hold), 0);

        // Reset mid-operation: immediate return to IDLE, no clear pulse.
        wait_until(h + 20);
        btn_start = 1'b0;
        btn_lap   = 1'b0;
        reset     = 1'b1;
        #1;
        check_all_zero("midreset");
        repeat (3) @(posedge clk);
        #1;
        check("midreset_no_clear", int'(clear), 0);
        check("state_q_empty", state_q.size(), 0);
        check("tick_q_empty", tick_q.size(), 0);
        check("clear_q_empty", clear_q.size(), 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
`default_nettype wire
